// File: rtl/audio_voice_mixer.sv
// Multi-voice PCM playback engine and mixer.
// Time-multiplexed ROM fetch, saturated stereo output to the Audio Core.
module audio_voice_mixer #(
  parameter int N_VOICES = 4,
  parameter int N_CLIPS  = 8,
  parameter int ADDR_W   = 18,
  parameter int SAMPLE_W = 8,
  parameter int OUT_W    = 16,
  localparam int CLIP_W  = $clog2(N_CLIPS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                chipselect,
  input  logic                write,
  input  logic                read,
  input  logic [3:0]          address,
  input  logic [7:0]          writedata,
  output logic [7:0]          readdata,
  output logic [CLIP_W-1:0]   clip_sel,
  input  logic [ADDR_W-1:0]   clip_begin,
  input  logic [ADDR_W-1:0]   clip_end,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [SAMPLE_W-1:0] rom_q,
  input  logic                left_chan_ready,
  input  logic                right_chan_ready,
  output logic [OUT_W-1:0]    sample_data_l,
  output logic [OUT_W-1:0]    sample_data_r,
  output logic                sample_valid_l,
  output logic                sample_valid_r
);

  localparam int VI_W   = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam int PROD_W = SAMPLE_W + 9;
  localparam int ACC_W  = SAMPLE_W + 9 + $clog2(N_VOICES);
  localparam int SH     = OUT_W - SAMPLE_W - 7;
  localparam int WIDE_W = ACC_W + SH;

  typedef enum logic [2:0] {
    IDLE, FETCH, DRAIN, SAT, OUT
  } state_t;

  state_t state, state_nxt;

  logic                      enable;
  logic [2:0]                vsel;
  logic [ADDR_W-1:0]         ptr [N_VOICES];
  logic [ADDR_W-1:0]         bgn [N_VOICES];
  logic [ADDR_W-1:0]         fin [N_VOICES];
  logic [7:0]                vol [N_VOICES];
  logic [N_VOICES-1:0]       loop;
  logic [N_VOICES-1:0]       active;
  logic [VI_W-1:0]           kcnt;
  logic [VI_W-1:0]           acc_idx;
  logic                      acc_vld;
  logic signed [ACC_W-1:0]   acc;
  logic signed [OUT_W-1:0]   mix;
  logic signed [PROD_W-1:0]  prod;
  logic signed [WIDE_W-1:0]  wide;
  logic [WIDE_W-OUT_W:0]     hi;
  logic [OUT_W-1:0]          sat;
  logic                      fetch;
  logic                      out_fire;
  logic                      ready_both;
  logic                      last_k;
  logic                      wr;
  logic                      vsel_ok;
  logic [VI_W-1:0]           vidx;
  logic                      wr_trig;
  logic                      wr_vol;
  logic                      wr_stop;
  logic                      stop_all;

  assign clip_sel   = writedata[CLIP_W-1:0];
  assign ready_both = left_chan_ready && right_chan_ready;
  assign last_k     = (kcnt == VI_W'(N_VOICES - 1));
  assign wr         = chipselect && write;
  assign vsel_ok    = ({1'b0, vsel} < 4'(N_VOICES));
  assign vidx       = vsel[VI_W-1:0];
  assign wr_trig    = wr && (address == 4'd2) && vsel_ok;
  assign wr_vol     = wr && (address == 4'd3) && vsel_ok;
  assign wr_stop    = wr && (address == 4'd4) && vsel_ok;
  assign stop_all   = wr && (address == 4'd0) && writedata[1];
  assign prod       = $signed(rom_q) * $signed({1'b0, vol[acc_idx]});

  assign sample_data_r  = sample_data_l;
  assign sample_valid_r = sample_valid_l;

  // Scale the accumulator to output range and clamp
  always_comb begin
    wide = WIDE_W'(acc) <<< SH;
    hi   = wide[WIDE_W-1:OUT_W-1];
    sat  = wide[OUT_W-1:0];
    if (!((&hi) || !(|hi)))
      sat = wide[WIDE_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                           : {1'b0, {(OUT_W-1){1'b1}}};
  end

  // Global control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      enable <= 1'b0;
      vsel   <= 3'd0;
    end else if (wr) begin
      if (address == 4'd0) enable <= writedata[0];
      if (address == 4'd1) vsel <= writedata[2:0];
    end
  end

  // Per-voice state; CPU writes win over the playback update
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_VOICES; i++) begin
        ptr[i]    <= '0;
        bgn[i]    <= '0;
        fin[i]    <= '0;
        vol[i]    <= 8'd128;
        loop[i]   <= 1'b0;
        active[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N_VOICES; i++) begin
        if (stop_all) begin
          active[i] <= 1'b0;
        end else if (wr_trig && vidx == VI_W'(i)) begin
          ptr[i]    <= clip_begin;
          bgn[i]    <= clip_begin;
          fin[i]    <= clip_end;
          loop[i]   <= writedata[7];
          active[i] <= (clip_begin <= clip_end);
        end else if (wr_stop && vidx == VI_W'(i)) begin
          active[i] <= 1'b0;
        end else if (acc_vld && acc_idx == VI_W'(i) && active[i]) begin
          if (ptr[i] < fin[i]) ptr[i] <= ptr[i] + 1'b1;
          else if (loop[i])    ptr[i] <= bgn[i];
          else                 active[i] <= 1'b0;
        end
        if (wr_vol && vidx == VI_W'(i)) vol[i] <= writedata;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (enable && ready_both) state_nxt = FETCH;
      FETCH: if (last_k) state_nxt = DRAIN;
      DRAIN: state_nxt = SAT;
      SAT:   state_nxt = OUT;
      OUT:   if (ready_both) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: ROM address during fetch, output handshake
  always_comb begin
    fetch    = 1'b0;
    out_fire = 1'b0;
    rom_addr = '0;
    unique case (state)
      FETCH: begin
        fetch    = 1'b1;
        rom_addr = ptr[kcnt];
      end
      OUT:     out_fire = ready_both;
      default: ;
    endcase
  end

  // Voice counter, accumulate pipeline and mix register
  always_ff @(posedge clk) begin
    if (reset) begin
      kcnt    <= '0;
      acc_idx <= '0;
      acc_vld <= 1'b0;
      acc     <= '0;
      mix     <= '0;
    end else begin
      kcnt    <= (fetch && !last_k) ? kcnt + 1'b1 : '0;
      acc_idx <= kcnt;
      acc_vld <= fetch;
      if (state == IDLE)
        acc <= '0;
      else if (acc_vld && active[acc_idx])
        acc <= acc + ACC_W'(prod);
      if (state == SAT) mix <= $signed(sat);
    end
  end

  // Registered sample output and status readback
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_valid_l <= 1'b0;
      sample_data_l  <= '0;
      readdata       <= 8'd0;
    end else begin
      sample_valid_l <= out_fire;
      if (out_fire) sample_data_l <= mix;
      if (chipselect && read && address == 4'd0)
        readdata <= 8'(active);
      else
        readdata <= 8'd0;
    end
  end

endmodule

// File: tb/tb_audio_voice_mixer.sv
// Directed self-checking bench for audio_voice_mixer.
// ROM and clip table modelled behaviourally; samples captured in a queue.
module tb_audio_voice_mixer;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect, write, read;
  logic [3:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic [2:0]  clip_sel;
  logic [17:0] clip_begin, clip_end;
  logic [17:0] rom_addr;
  logic [7:0]  rom_q;
  logic        left_chan_ready, right_chan_ready;
  logic [15:0] sample_data_l, sample_data_r;
  logic        sample_valid_l, sample_valid_r;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rom [0:262143];
  logic [17:0] cb [8];
  logic [17:0] ce [8];
  logic [33:0] q [$];

  audio_voice_mixer dut (
    .clk(clk), .reset(reset),
    .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .clip_sel(clip_sel), .clip_begin(clip_begin), .clip_end(clip_end),
    .rom_addr(rom_addr), .rom_q(rom_q),
    .left_chan_ready(left_chan_ready), .right_chan_ready(right_chan_ready),
    .sample_data_l(sample_data_l), .sample_data_r(sample_data_r),
    .sample_valid_l(sample_valid_l), .sample_valid_r(sample_valid_r)
  );

  always #5 clk = ~clk;

  assign clip_begin = cb[clip_sel];
  assign clip_end   = ce[clip_sel];

  always @(posedge clk) rom_q <= rom[rom_addr];

  always @(posedge clk) begin
    #1;
    if (sample_valid_l || sample_valid_r)
      q.push_back({sample_valid_r, sample_valid_l,
                   sample_data_r, sample_data_l});
  end

  function automatic logic [33:0] pk(input logic [15:0] v);
    return {2'b11, v, v};
  endfunction

  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic get_sample(input string nm, output logic [33:0] s);
    int n = 0;
    while (q.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: no sample within 200 cycles", nm);
      s = 'x;
    end else begin
      s = q.pop_front();
    end
  endtask

  task automatic wait_addr(input logic [17:0] a);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rom_addr != a && n < 100);
    if (rom_addr != a) begin
      checks++; errors++;
      $display("FAIL wait_addr: rom_addr %h never seen", a);
    end
  endtask

  task automatic quiesce();
    cpu_wr(4'd0, 8'h02);
    wait_cycles(20);
    q.delete();
  endtask

  task automatic test_reset();
    logic [7:0] st;
    checks++;
    if ({sample_valid_l, sample_valid_r} !== 2'b00) begin
      errors++; $display("FAIL reset_valid: got %b want 00",
                         {sample_valid_l, sample_valid_r});
    end
    checks++;
    if ({sample_data_l, sample_data_r} !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0",
                         {sample_data_l, sample_data_r});
    end
    checks++;
    if (rom_addr !== 18'h0 || readdata !== 8'h0) begin
      errors++; $display("FAIL reset_addr_rd: got %h/%h want 0/0",
                         rom_addr, readdata);
    end
    cpu_rd(4'd0, st);
    checks++;
    if (st !== 8'h00) begin
      errors++; $display("FAIL reset_status: got %h want 00", st);
    end
    wait_cycles(30);
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL reset_novalid: got %0d samples want 0",
                         q.size());
    end
  endtask

  task automatic test_single_voice();
    logic [33:0] s;
    logic [7:0]  st;
    logic [15:0] exp_v [5] = '{16'h7F00, 16'h8000, 16'h0100,
                               16'h0000, 16'h0000};
    quiesce();
    cpu_wr(4'd1, 8'd0);
    cpu_wr(4'd3, 8'd128);
    cpu_wr(4'd2, 8'h00);
    cpu_rd(4'd0, st);
    checks++;
    if (st !== 8'h01) begin
      errors++; $display("FAIL single_trig_status: got %h want 01", st);
    end
    q.delete();
    cpu_wr(4'd0, 8'h01);
    for (int i = 0; i < 5; i++) begin
      get_sample("single", s);
      checks++;
      if (s !== pk(exp_v[i])) begin
        errors++; $display("FAIL single[%0d]: got %h want %h",
                           i, s, pk(exp_v[i]));
      end
    end
    cpu_rd(4'd0, st);
    checks++;
    if (st !== 8'h00) begin
      errors++; $display("FAIL single_end_status: got %h want 00", st);
    end
  endtask

  task automatic test_loop_wrap();
    logic [33:0] s;
    logic [7:0]  st;
    logic [15:0] pat [4] = '{16'h7F00, 16'h8000, 16'h0100, 16'h0000};
    quiesce();
    cpu_wr(4'd1, 8'd0);
    cpu_wr(4'd2, 8'h80);
    q.delete();
    cpu_wr(4'd0, 8'h01);
    for (int i = 0; i < 12; i++) begin
      get_sample("loop", s);
      checks++;
      if (s !== pk(pat[i % 4])) begin
        errors++; $display("FAIL loop[%0d]: got %h want %h",
                           i, s, pk(pat[i % 4]));
      end
    end
    cpu_rd(4'd0, st);
    checks++;
    if (st !== 8'h01) begin
      errors++; $display("FAIL loop_status: got %h want 01", st);
    end
  endtask

  task automatic test_saturation();
    logic [33:0] s;
    logic [7:0]  st;
    quiesce();
    for (int i = 0; i < 4; i++) begin
      cpu_wr(4'd1, 8'(i));
      cpu_wr(4'd3, 8'd255);
      cpu_wr(4'd2, 8'h01);
    end
    cpu_wr(4'd1, 8'd5);
    cpu_wr(4'd4, 8'h00);
    cpu_rd(4'd0, st);
    checks++;
    if (st !== 8'h0F) begin
      errors++; $display("FAIL vsel_oob_status: got %h want 0f", st);
    end
    q.delete();
    cpu_wr(4'd0, 8'h01);
    get_sample("sat_pos", s);
    checks++;
    if (s !== pk(16'h7FFF)) begin
      errors++; $display("FAIL sat_pos: got %h want %h", s, pk(16'h7FFF));
    end
    quiesce();
    for (int i = 0; i < 4; i++) begin
      cpu_wr(4'd1, 8'(i));
      cpu_wr(4'd2, 8'h02);
    end
    q.delete();
    cpu_wr(4'd0, 8'h01);
    get_sample("sat_neg", s);
    checks++;
    if (s !== pk(16'h8000)) begin
      errors++; $display("FAIL sat_neg: got %h want %h", s, pk(16'h8000));
    end
  endtask

  task automatic test_volume_mix();
    logic [33:0] s;
    logic [7:0]  st;
    quiesce();
    cpu_wr(4'd1, 8'd0);
    cpu_wr(4'd3, 8'd64);
    cpu_wr(4'd2, 8'h03);
    cpu_wr(4'd1, 8'd1);
    cpu_wr(4'd3, 8'd128);
    cpu_wr(4'd2, 8'h04);
    q.delete();
    cpu_wr(4'd0, 8'h01);
    get_sample("mix", s);
    checks++;
    if (s !== pk(16'h4000)) begin
      errors++; $display("FAIL mix: got %h want %h", s, pk(16'h4000));
    end
    get_sample("mix_after", s);
    checks++;
    if (s !== pk(16'h0000)) begin
      errors++; $display("FAIL mix_after: got %h want %h", s, pk(16'h0));
    end
    quiesce();
    cpu_wr(4'd1, 8'd0);
    cpu_wr(4'd3, 8'd128);
    cpu_wr(4'd2, 8'h00);
    cpu_wr(4'd2, 8'h05);
    cpu_rd(4'd0, st);
    checks++;
    if (st !== 8'h00) begin
      errors++; $display("FAIL bad_clip_status: got %h want 00", st);
    end
  endtask

  task automatic test_retrigger_stop();
    logic [33:0] s;
    logic [7:0]  st;
    logic [15:0] exp_v [5] = '{16'h4000, 16'h1000, 16'h1100,
                               16'h1000, 16'h1100};
    quiesce();
    cpu_wr(4'd1, 8'd0);
    cpu_wr(4'd3, 8'd128);
    cpu_wr(4'd2, 8'h03);
    cpu_wr(4'd0, 8'h01);
    wait_addr(18'h400);
    cpu_wr(4'd2, 8'h86);
    for (int i = 0; i < 5; i++) begin
      get_sample("retrig", s);
      checks++;
      if (s !== pk(exp_v[i])) begin
        errors++; $display("FAIL retrig[%0d]: got %h want %h",
                           i, s, pk(exp_v[i]));
      end
    end
    cpu_wr(4'd0, 8'h03);
    wait_cycles(30);
    q.delete();
    for (int i = 0; i < 2; i++) begin
      get_sample("stop_all", s);
      checks++;
      if (s !== pk(16'h0000)) begin
        errors++; $display("FAIL stop_all_silence[%0d]: got %h want %h",
                           i, s, pk(16'h0));
      end
    end
    cpu_rd(4'd0, st);
    checks++;
    if (st !== 8'h00) begin
      errors++; $display("FAIL stop_all_status: got %h want 00", st);
    end
  endtask

  task automatic test_handshake();
    quiesce();
    cpu_wr(4'd1, 8'd0);
    cpu_wr(4'd2, 8'h03);
    q.delete();
    cpu_wr(4'd0, 8'h01);
    wait_addr(18'h400);
    left_chan_ready  = 1'b0;
    right_chan_ready = 1'b0;
    wait_cycles(20);
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL hs_withheld: got %0d samples want 0",
                         q.size());
    end
    left_chan_ready  = 1'b1;
    right_chan_ready = 1'b1;
    wait_cycles(6);
    checks++;
    if (q.size() != 1) begin
      errors++; $display("FAIL hs_once: got %0d pulses want 1", q.size());
    end else if (q[0] !== pk(16'h4000)) begin
      errors++; $display("FAIL hs_data: got %h want %h", q[0],
                         pk(16'h4000));
    end
  endtask

  task automatic test_reset_midfetch();
    logic [33:0] s;
    logic [7:0]  st;
    quiesce();
    cpu_wr(4'd1, 8'd0);
    cpu_wr(4'd3, 8'd200);
    cpu_wr(4'd2, 8'h83);
    cpu_wr(4'd1, 8'd2);
    q.delete();
    cpu_wr(4'd0, 8'h01);
    get_sample("pre_reset", s);
    checks++;
    if (s !== pk(16'h6400)) begin
      errors++; $display("FAIL pre_reset: got %h want %h", s, pk(16'h6400));
    end
    wait_addr(18'h400);
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    checks++;
    if ({sample_valid_l, sample_valid_r, sample_data_l, sample_data_r,
         rom_addr, readdata} !== '0) begin
      errors++; $display("FAIL midreset_out: got %b%b %h %h %h %h want 0",
                         sample_valid_l, sample_valid_r, sample_data_l,
                         sample_data_r, rom_addr, readdata);
    end
    q.delete();
    cpu_rd(4'd0, st);
    checks++;
    if (st !== 8'h00) begin
      errors++; $display("FAIL midreset_status: got %h want 00", st);
    end
    wait_cycles(30);
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL midreset_novalid: got %0d want 0", q.size());
    end
    cpu_wr(4'd2, 8'h03);
    cpu_rd(4'd0, st);
    checks++;
    if (st !== 8'h01) begin
      errors++; $display("FAIL midreset_vsel: got %h want 01", st);
    end
    q.delete();
    cpu_wr(4'd0, 8'h01);
    get_sample("post_reset", s);
    checks++;
    if (s !== pk(16'h4000)) begin
      errors++; $display("FAIL post_reset_vol: got %h want %h",
                         s, pk(16'h4000));
    end
  endtask

  initial begin
    cb = '{18'h100, 18'h200, 18'h300, 18'h400,
           18'h500, 18'h600, 18'h700, 18'h000};
    ce = '{18'h103, 18'h203, 18'h303, 18'h400,
           18'h500, 18'h5FF, 18'h701, 18'h000};
    rom[18'h100] = 8'h7F; rom[18'h101] = 8'h80;
    rom[18'h102] = 8'h01; rom[18'h103] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      rom[18'h200 + i] = 8'h7F;
      rom[18'h300 + i] = 8'h80;
    end
    rom[18'h400] = 8'h40;
    rom[18'h500] = 8'h20;
    rom[18'h700] = 8'h10; rom[18'h701] = 8'h11;
    reset = 1'b1;
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = 4'd0; writedata = 8'd0;
    left_chan_ready = 1'b1; right_chan_ready = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    test_reset();
    test_single_voice();
    test_loop_wrap();
    test_saturation();
    test_volume_mix();
    test_retrigger_stop();
    test_handshake();
    test_reset_midfetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
